// File: rtl/dma_pkg.sv
// Shared types and default constants for the UART boot loader / receive DMA.
package dma_pkg;

    typedef enum logic [2:0] {
        SEND_HELLO,
        RECV_SIZE,
        RECV_CODE,
        SEND_ACK,
        RUN
    } dma_state_t;

    localparam logic [7:0]  HELLO_BYTE_DEFAULT      = 8'h99;
    localparam logic [7:0]  ACK_BYTE_DEFAULT        = 8'haa;
    localparam logic [31:0] MAX_INSTR_WORDS_DEFAULT = 32'h6c00;

endpackage

// File: rtl/uart_boot_dma_byte_word_packer.sv
// Packs received UART bytes little-endian into 32-bit words; the word is presented
// combinationally on the strobe that carries its fourth byte.
module byte_word_packer (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_ready,
    input  logic [7:0]  rdata,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  r_cnt;
    logic [23:0] r_shift;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt   <= 2'd0;
            r_shift <= 24'd0;
        end else if (rx_ready) begin
            r_cnt <= r_cnt + 2'd1;
            case (r_cnt)
                2'd0:    r_shift[7:0]   <= rdata;
                2'd1:    r_shift[15:8]  <= rdata;
                2'd2:    r_shift[23:16] <= rdata;
                default: r_shift        <= 24'd0;
            endcase
        end
    end

    assign word_valid = rx_ready && (r_cnt == 2'd3);
    assign word       = {rdata, r_shift};

endmodule

// File: rtl/uart_boot_dma.sv
// Boot loader and receive DMA: announces readiness, loads the program image into
// instruction BRAM, acknowledges, then streams every received word to the hub.
module uart_boot_dma
    import dma_pkg::*;
#(
    parameter logic [31:0] MAX_INSTR_WORDS = MAX_INSTR_WORDS_DEFAULT,
    parameter logic [7:0]  HELLO_BYTE      = HELLO_BYTE_DEFAULT,
    parameter logic [7:0]  ACK_BYTE        = ACK_BYTE_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_ready,
    input  logic [7:0]  rdata,
    output logic        tx_start,
    output logic [7:0]  sdata,
    input  logic        tx_busy,
    output logic        iw_en,
    output logic [31:0] iw_addr,
    output logic [31:0] iw_data,
    output logic        boot_done,
    output logic        data_ready,
    output logic [31:0] data
);

    dma_state_t  r_state;
    dma_state_t  w_next;
    logic [31:0] r_size;
    logic [31:0] r_word_cnt;

    logic        w_pack_en;
    logic        w_word_valid;
    logic [31:0] w_word;

    logic        w_tx_fire;
    logic [7:0]  w_tx_byte;
    logic        w_iw_wr;
    logic        w_rx_out;
    logic        w_size_ld;
    logic        w_cnt_inc;
    logic        w_done_set;

    logic        r_tx_start_p1;
    logic [7:0]  r_sdata_p1;
    logic        r_iw_en_p1;
    logic [31:0] r_iw_addr_p1;
    logic [31:0] r_iw_data_p1;
    logic        r_data_ready_p1;
    logic [31:0] r_data_p1;
    logic        r_boot_done;

    // Bytes arriving before HELLO has gone out belong to no word and are dropped.
    assign w_pack_en = rx_ready && (r_state != SEND_HELLO);

    byte_word_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .rx_ready   (w_pack_en),
        .rdata      (rdata),
        .word_valid (w_word_valid),
        .word       (w_word)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= SEND_HELLO;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_tx_fire  = 1'b0;
        w_tx_byte  = 8'h00;
        w_iw_wr    = 1'b0;
        w_rx_out   = 1'b0;
        w_size_ld  = 1'b0;
        w_cnt_inc  = 1'b0;
        w_done_set = 1'b0;
        case (r_state)
            SEND_HELLO: begin
                if (!tx_busy) begin
                    w_tx_fire = 1'b1;
                    w_tx_byte = HELLO_BYTE;
                    w_next    = RECV_SIZE;
                end
            end
            RECV_SIZE: begin
                if (w_word_valid) begin
                    w_size_ld = 1'b1;
                    w_next    = (w_word == 32'd0) ? SEND_ACK : RECV_CODE;
                end
            end
            RECV_CODE: begin
                if (w_word_valid) begin
                    w_cnt_inc = 1'b1;
                    w_iw_wr   = (r_word_cnt < MAX_INSTR_WORDS);
                    // r_size is nonzero here, so size-1 cannot underflow even for N = 2^32-1.
                    if (r_word_cnt == r_size - 32'd1) begin
                        w_next = SEND_ACK;
                    end
                end
            end
            SEND_ACK: begin
                w_rx_out = w_word_valid;
                if (!tx_busy) begin
                    w_tx_fire  = 1'b1;
                    w_tx_byte  = ACK_BYTE;
                    w_done_set = 1'b1;
                    w_next     = RUN;
                end
            end
            RUN: begin
                w_rx_out = w_word_valid;
            end
            default: begin
                w_next = SEND_HELLO;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_size     <= 32'd0;
            r_word_cnt <= 32'd0;
        end else begin
            if (w_size_ld) begin
                r_size <= w_word;
            end
            if (w_cnt_inc) begin
                r_word_cnt <= r_word_cnt + 32'd1;
            end
        end
    end

    // ---- output stage: decisions at cycle t appear on the ports at t+1 ----
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx_start_p1   <= 1'b0;
            r_sdata_p1      <= 8'h00;
            r_iw_en_p1      <= 1'b0;
            r_iw_addr_p1    <= 32'd0;
            r_iw_data_p1    <= 32'd0;
            r_data_ready_p1 <= 1'b0;
            r_data_p1       <= 32'd0;
            r_boot_done     <= 1'b0;
        end else begin
            r_tx_start_p1   <= w_tx_fire;
            r_sdata_p1      <= w_tx_byte;
            r_iw_en_p1      <= w_iw_wr;
            r_data_ready_p1 <= w_rx_out;
            if (w_iw_wr) begin
                r_iw_addr_p1 <= r_word_cnt;
                r_iw_data_p1 <= w_word;
            end
            if (w_rx_out) begin
                r_data_p1 <= w_word;
            end
            if (w_done_set) begin
                r_boot_done <= 1'b1;
            end
        end
    end

    assign tx_start   = r_tx_start_p1;
    assign sdata      = r_sdata_p1;
    assign iw_en      = r_iw_en_p1;
    assign iw_addr    = r_iw_addr_p1;
    assign iw_data    = r_iw_data_p1;
    assign data_ready = r_data_ready_p1;
    assign data       = r_data_p1;
    assign boot_done  = r_boot_done;

endmodule

// File: tb/tb_uart_boot_dma.sv
// Scoreboard bench for uart_boot_dma: expected TX bytes, BRAM writes and hub words
// are queued as stimulus is driven and matched by a monitor as the DUT emits them.
module tb_uart_boot_dma;

    localparam int K_TX = 0;
    localparam int K_IW = 1;
    localparam int K_DR = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] val;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        rx_ready;
    logic [7:0]  rdata;
    logic        tx_start;
    logic [7:0]  sdata;
    logic        tx_busy;
    logic        iw_en;
    logic [31:0] iw_addr;
    logic [31:0] iw_data;
    logic        boot_done;
    logic        data_ready;
    logic [31:0] data;

    exp_t q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    int   tx_cnt = 0;
    int   iw_cnt = 0;
    int   dr_cnt = 0;

    uart_boot_dma #(.MAX_INSTR_WORDS(32'd4)) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_ready   (rx_ready),
        .rdata      (rdata),
        .tx_start   (tx_start),
        .sdata      (sdata),
        .tx_busy    (tx_busy),
        .iw_en      (iw_en),
        .iw_addr    (iw_addr),
        .iw_data    (iw_data),
        .boot_done  (boot_done),
        .data_ready (data_ready),
        .data       (data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge clock) begin
        if (iw_en === 1'b1 && data_ready === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL exclusive iw_en=%b data_ready=%b required not both", iw_en, data_ready);
        end
        if (tx_start === 1'b1) begin
            tx_cnt++;
            checks++;
            if (tx_busy === 1'b1) begin
                errors++;
                $display("FAIL tx_while_busy tx_start=1 tx_busy=1");
            end else if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_tx sdata=%h required no pulse", sdata);
            end else begin
                e = q.pop_front();
                if (e.kind != K_TX || sdata !== e.val[7:0]) begin
                    errors++;
                    $display("FAIL tx_byte got kind=%0d sdata=%h required kind=%0d sdata=%h",
                             K_TX, sdata, e.kind, e.val[7:0]);
                end
            end
        end
        if (iw_en === 1'b1) begin
            iw_cnt++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_iw addr=%h data=%h required no write", iw_addr, iw_data);
            end else begin
                e = q.pop_front();
                if (e.kind != K_IW || iw_addr !== e.addr || iw_data !== e.val) begin
                    errors++;
                    $display("FAIL iw_write got addr=%h data=%h required kind=%0d addr=%h data=%h",
                             iw_addr, iw_data, e.kind, e.addr, e.val);
                end
            end
        end
        if (data_ready === 1'b1) begin
            dr_cnt++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_data data=%h required no strobe", data);
            end else begin
                e = q.pop_front();
                if (e.kind != K_DR || data !== e.val) begin
                    errors++;
                    $display("FAIL data_word got data=%h required kind=%0d data=%h",
                             data, e.kind, e.val);
                end
            end
        end
    end

    task automatic push(input int kind, input logic [31:0] addr, input logic [31:0] val);
        exp_t x;
        x.kind = kind;
        x.addr = addr;
        x.val  = val;
        q.push_back(x);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clock);
        #1;
        rx_ready = 1'b1;
        rdata    = b;
        @(posedge clock);
        #1;
        rx_ready = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
        end
    endtask

    task automatic apply_reset();
        rx_ready = 1'b0;
        rdata    = 8'h00;
        reset    = 1'b1;
        cycles(3);
        push(K_TX, 32'd0, 32'h99);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        tx_busy  = 1'b0;
        rx_ready = 1'b0;
        rdata    = 8'h00;
        reset    = 1'b1;
        cycles(3);
        checks++;
        if ({tx_start, sdata, iw_en, iw_addr, iw_data, boot_done, data_ready, data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs tx=%b sdata=%h iw=%b addr=%h idata=%h done=%b dr=%b data=%h required all 0",
                     tx_start, sdata, iw_en, iw_addr, iw_data, boot_done, data_ready, data);
        end
        push(K_TX, 32'd0, 32'h99);
        reset = 1'b0;
        cycles(10);
        checks++;
        if (tx_cnt != 1 || iw_cnt != 0 || dr_cnt != 0 || boot_done !== 1'b0) begin
            errors++;
            $display("FAIL hello_once tx=%0d iw=%0d dr=%0d done=%b required 1 0 0 0",
                     tx_cnt, iw_cnt, dr_cnt, boot_done);
        end
    endtask

    task automatic test_boot();
        logic [31:0] words [3];
        int          iw0;
        int          tx0;
        words[0] = 32'h11223344;
        words[1] = 32'h55667788;
        words[2] = 32'h99aabbcc;
        iw0 = iw_cnt;
        tx0 = tx_cnt;
        send_word(32'd3);
        for (int i = 0; i < 3; i++) begin
            push(K_IW, i, words[i]);
            send_word(words[i]);
            if (i == 1) begin
                checks++;
                if (boot_done !== 1'b0) begin
                    errors++;
                    $display("FAIL done_early boot_done=%b required 0", boot_done);
                end
            end
        end
        push(K_TX, 32'd0, 32'haa);
        cycles(5);
        checks++;
        if (boot_done !== 1'b1 || iw_cnt - iw0 != 3 || tx_cnt - tx0 != 1) begin
            errors++;
            $display("FAIL boot_result done=%b writes=%0d tx=%0d required 1 3 1",
                     boot_done, iw_cnt - iw0, tx_cnt - tx0);
        end
    endtask

    task automatic test_run();
        int iw0;
        iw0 = iw_cnt;
        push(K_DR, 32'd0, 32'h12345678);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        checks++;
        if (data_ready !== 1'b0) begin
            errors++;
            $display("FAIL run_early data_ready=%b required 0", data_ready);
        end
        send_byte(8'h12);
        checks++;
        if (data_ready !== 1'b1 || data !== 32'h12345678) begin
            errors++;
            $display("FAIL run_latency data_ready=%b data=%h required 1 12345678", data_ready, data);
        end
        cycles(1);
        checks++;
        if (data_ready !== 1'b0 || iw_cnt != iw0) begin
            errors++;
            $display("FAIL run_one_cycle data_ready=%b writes=%0d required 0 0", data_ready, iw_cnt - iw0);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] stream;
        int          dr0;
        stream = 64'hcafef00d_0badbeef;
        dr0 = dr_cnt;
        push(K_DR, 32'd0, stream[31:0]);
        push(K_DR, 32'd0, stream[63:32]);
        @(posedge clock);
        #1;
        for (int k = 0; k < 8; k++) begin
            rx_ready = 1'b1;
            rdata    = stream[8*k +: 8];
            @(posedge clock);
            #1;
        end
        rx_ready = 1'b0;
        cycles(3);
        checks++;
        if (dr_cnt - dr0 != 2) begin
            errors++;
            $display("FAIL b2b_count strobes=%0d required 2", dr_cnt - dr0);
        end
    endtask

    task automatic test_max_words();
        int iw0;
        apply_reset();
        cycles(3);
        iw0 = iw_cnt;
        send_word(32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                push(K_IW, i, 32'hA000_0000 + i);
            end
            send_word(32'hA000_0000 + i);
        end
        push(K_TX, 32'd0, 32'haa);
        cycles(5);
        checks++;
        if (iw_cnt - iw0 != 4 || boot_done !== 1'b1) begin
            errors++;
            $display("FAIL max_words writes=%0d done=%b required 4 1", iw_cnt - iw0, boot_done);
        end
    endtask

    task automatic test_zero_size();
        int iw0;
        apply_reset();
        cycles(3);
        iw0 = iw_cnt;
        send_word(32'd0);
        push(K_TX, 32'd0, 32'haa);
        cycles(5);
        checks++;
        if (boot_done !== 1'b1 || iw_cnt != iw0) begin
            errors++;
            $display("FAIL zero_size done=%b writes=%0d required 1 0", boot_done, iw_cnt - iw0);
        end
    endtask

    task automatic test_tx_busy();
        int tx0;
        tx_busy = 1'b1;
        apply_reset();
        tx0 = tx_cnt;
        send_byte(8'h05);
        send_byte(8'h07);
        cycles(100);
        checks++;
        if (tx_cnt != tx0) begin
            errors++;
            $display("FAIL hello_held pulses=%0d required 0", tx_cnt - tx0);
        end
        tx_busy = 1'b0;
        cycles(3);
        checks++;
        if (tx_cnt - tx0 != 1) begin
            errors++;
            $display("FAIL hello_release pulses=%0d required 1", tx_cnt - tx0);
        end
        tx_busy = 1'b1;
        send_word(32'd0);
        cycles(100);
        checks++;
        if (tx_cnt - tx0 != 1 || boot_done !== 1'b0) begin
            errors++;
            $display("FAIL ack_held pulses=%0d done=%b required 1 0", tx_cnt - tx0, boot_done);
        end
        push(K_TX, 32'd0, 32'haa);
        tx_busy = 1'b0;
        cycles(3);
        checks++;
        if (tx_cnt - tx0 != 2 || boot_done !== 1'b1) begin
            errors++;
            $display("FAIL ack_release pulses=%0d done=%b required 2 1", tx_cnt - tx0, boot_done);
        end
    endtask

    task automatic test_reset_midword();
        apply_reset();
        cycles(3);
        send_word(32'd3);
        send_byte(8'hde);
        send_byte(8'had);
        apply_reset();
        cycles(1);
        checks++;
        if (boot_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_done boot_done=%b required 0", boot_done);
        end
        cycles(3);
        send_word(32'd1);
        push(K_IW, 32'd0, 32'hfeedface);
        send_word(32'hfeedface);
        push(K_TX, 32'd0, 32'haa);
        cycles(5);
        checks++;
        if (boot_done !== 1'b1) begin
            errors++;
            $display("FAIL midreset_boot boot_done=%b required 1", boot_done);
        end
    endtask

    initial begin
        reset    = 1'b1;
        rx_ready = 1'b0;
        rdata    = 8'h00;
        tx_busy  = 1'b0;
        test_reset();
        test_boot();
        test_run();
        test_back_to_back();
        test_max_words();
        test_zero_size();
        test_tx_busy();
        test_reset_midword();
        cycles(5);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_expected outstanding=%0d required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
